// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;
    localparam int   CTR_W = 8;

    // On a tie the port that was not served last wins.
    function automatic logic pick_port(input logic [1:0] pending, input logic last_grant);
        if (pending == 2'b11)
            return ~last_grant;
        else if (pending[0])
            return PORT0;
        else
            return PORT1;
    endfunction

endpackage

// File: rtl/mem_wait_ctr.sv
// Wait-state down counter; flags the final wait cycle when the count reaches one.
module mem_wait_ctr
    import mem_arb_pkg::*;
#(
    parameter int W = CTR_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         count_is_one
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (load)
            count <= load_value;
        else if (dec && (count != '0))
            count <= count - 1'b1;
    end

    assign count_is_one = (count == W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one wait-stated memory between instruction and data cache ports.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW          = 16,
    parameter int DW          = 8,
    parameter int WAIT_CYCLES = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_strobe,
    input  logic          req0_rw,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          req0_ready,
    output logic [DW-1:0] req0_rdata,
    input  logic          req1_strobe,
    input  logic          req1_rw,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          req1_ready,
    output logic [DW-1:0] req1_rdata,
    output logic          mem_strobe,
    output logic          mem_rw,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          grant,
    output logic          busy
);

    state_t        state;
    logic          last_grant;
    logic          sel_port;
    logic          count_is_one;
    logic [1:0]    pending;
    logic [1:0]    strobe_in;
    logic [1:0]    clear;
    logic [1:0]    set;
    logic          rw_q    [2];
    logic [AW-1:0] addr_q  [2];
    logic [DW-1:0] wdata_q [2];

    assign strobe_in = {req1_strobe, req0_strobe};
    assign clear[0]  = (state == DONE) && (grant == PORT0);
    assign clear[1]  = (state == DONE) && (grant == PORT1);
    // A strobe landing on the same edge as the DONE clear re-arms the port.
    assign set       = strobe_in & (~pending | clear);
    assign sel_port  = pick_port(pending, last_grant);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
            for (int i = 0; i < 2; i++) begin
                rw_q[i]    <= 1'b0;
                addr_q[i]  <= '0;
                wdata_q[i] <= '0;
            end
        end else begin
            pending <= set | (pending & ~clear);
            if (set[0]) begin
                rw_q[0]    <= req0_rw;
                addr_q[0]  <= req0_addr;
                wdata_q[0] <= req0_wdata;
            end
            if (set[1]) begin
                rw_q[1]    <= req1_rw;
                addr_q[1]  <= req1_addr;
                wdata_q[1] <= req1_wdata;
            end
        end
    end

    mem_wait_ctr #(.W(CTR_W)) u_wait_ctr (
        .clk          (clk),
        .reset        (reset),
        .load         (state == ISSUE),
        .load_value   (CTR_W'(WAIT_CYCLES)),
        .dec          (state == WAIT),
        .count_is_one (count_is_one)
    );

    // Memory-side fields latch on entry to ISSUE; the granted port's captured
    // fields cannot change until its DONE edge, so this matches them throughout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= PORT1;
            grant      <= PORT0;
            busy       <= 1'b0;
            mem_strobe <= 1'b0;
            mem_rw     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            req0_rdata <= '0;
            req1_rdata <= '0;
        end else begin
            mem_strobe <= 1'b0;
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (|pending) begin
                        state      <= ISSUE;
                        grant      <= sel_port;
                        busy       <= 1'b1;
                        mem_strobe <= 1'b1;
                        mem_rw     <= rw_q[sel_port];
                        mem_addr   <= addr_q[sel_port];
                        mem_wdata  <= wdata_q[sel_port];
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (count_is_one) begin
                        state <= DONE;
                        if (grant == PORT0) begin
                            req0_ready <= 1'b1;
                            if (!mem_rw)
                                req0_rdata <= mem_rdata;
                        end else begin
                            req1_ready <= 1'b1;
                            if (!mem_rw)
                                req1_rdata <= mem_rdata;
                        end
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    last_grant <= grant;
                    mem_rw     <= 1'b0;
                    mem_addr   <= '0;
                    mem_wdata  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected accesses, monitors pop and compare.
module tb_mem_arbiter;

    typedef struct {
        int          port;
        logic        rw;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        int          issue_cyc;
        int          ready_cyc;
    } access_t;

    logic        clk = 1'b0;
    logic        reset;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic        req0_strobe, req0_rw, req1_strobe, req1_rw;
    logic [15:0] req0_addr, req1_addr, mem_addr;
    logic [7:0]  req0_wdata, req1_wdata, req0_rdata, req1_rdata, mem_wdata, mem_rdata;
    logic        req0_ready, req1_ready, mem_strobe, mem_rw, grant, busy;

    logic        b_req0_strobe;
    logic [15:0] b_req0_addr, b_mem_addr;
    logic [7:0]  b_req0_rdata, b_req1_rdata, b_mem_wdata, b_mem_rdata;
    logic        b_req0_ready, b_req1_ready, b_mem_strobe, b_mem_rw, b_grant, b_busy;

    access_t     q_issue [$];
    access_t     q_ready [$];
    access_t     q_b [$];
    access_t     mon_e;
    access_t     mon_b;
    logic [7:0]  exp_rdata [2];

    // Memory model: read data is a fixed function of the address.
    assign mem_rdata   = mem_addr[7:0] ^ 8'hB5;
    assign b_mem_rdata = b_mem_addr[7:0] ^ 8'hB5;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter #(.AW(16), .DW(8), .WAIT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .req0_strobe(req0_strobe), .req0_rw(req0_rw), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_ready(req0_ready), .req0_rdata(req0_rdata),
        .req1_strobe(req1_strobe), .req1_rw(req1_rw), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_ready(req1_ready), .req1_rdata(req1_rdata),
        .mem_strobe(mem_strobe), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .grant(grant), .busy(busy)
    );

    mem_arbiter #(.AW(16), .DW(8), .WAIT_CYCLES(1)) dut_w1 (
        .clk(clk), .reset(reset),
        .req0_strobe(b_req0_strobe), .req0_rw(1'b0), .req0_addr(b_req0_addr), .req0_wdata(8'h00),
        .req0_ready(b_req0_ready), .req0_rdata(b_req0_rdata),
        .req1_strobe(1'b0), .req1_rw(1'b0), .req1_addr(16'h0000), .req1_wdata(8'h00),
        .req1_ready(b_req1_ready), .req1_rdata(b_req1_rdata),
        .mem_strobe(b_mem_strobe), .mem_rw(b_mem_rw), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .grant(b_grant), .busy(b_busy)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic drive_port(input int port, input logic rw, input logic [15:0] addr, input logic [7:0] wdata);
        if (port == 0) begin
            req0_strobe = 1'b1; req0_rw = rw; req0_addr = addr; req0_wdata = wdata;
        end else begin
            req1_strobe = 1'b1; req1_rw = rw; req1_addr = addr; req1_wdata = wdata;
        end
    endtask

    task automatic apply_stimulus();
        @(posedge clk);
        #1;
        req0_strobe   = 1'b0;
        req1_strobe   = 1'b0;
        b_req0_strobe = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_access(input int port, input logic rw, input logic [15:0] addr, input logic [7:0] wdata,
                                 input int issue_cyc, input int ready_cyc, input bit with_ready);
        access_t e;
        e.port = port; e.rw = rw; e.addr = addr; e.wdata = wdata;
        e.issue_cyc = issue_cyc; e.ready_cyc = ready_cyc;
        if (with_ready && !rw)
            exp_rdata[port] = addr[7:0] ^ 8'hB5;
        e.rdata = exp_rdata[port];
        q_issue.push_back(e);
        if (with_ready)
            q_ready.push_back(e);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_output({tag, "_mem_strobe"}, mem_strobe, 0);
        check_output({tag, "_busy"}, busy, 0);
        check_output({tag, "_grant"}, grant, 0);
        check_output({tag, "_ready"}, {req1_ready, req0_ready}, 0);
        check_output({tag, "_mem_rw"}, mem_rw, 0);
        check_output({tag, "_mem_addr"}, mem_addr, 0);
        check_output({tag, "_mem_wdata"}, mem_wdata, 0);
        check_output({tag, "_rdata0"}, req0_rdata, 0);
        check_output({tag, "_rdata1"}, req1_rdata, 0);
    endtask

    // Main DUT monitor: memory starts and ready pulses are popped from their queues.
    always @(negedge clk) begin
        if (mem_strobe) begin
            if (q_issue.size() == 0) begin
                checks++; errors++;
                $display("[TB] FAIL unexpected_strobe: mem_strobe=1 at cycle %0d, expected none", cyc);
            end else begin
                mon_e = q_issue.pop_front();
                check_output("issue_cycle", cyc, mon_e.issue_cyc);
                check_output("issue_grant", grant, mon_e.port);
                check_output("issue_rw", mem_rw, mon_e.rw);
                check_output("issue_addr", mem_addr, mon_e.addr);
                check_output("issue_wdata", mem_wdata, mon_e.wdata);
            end
        end
        if (req0_ready || req1_ready) begin
            check_output("ready_exclusive", req0_ready & req1_ready, 0);
            if (q_ready.size() == 0) begin
                checks++; errors++;
                $display("[TB] FAIL unexpected_ready: ready={%0b,%0b} at cycle %0d, expected none", req1_ready, req0_ready, cyc);
            end else begin
                mon_e = q_ready.pop_front();
                check_output("ready_cycle", cyc, mon_e.ready_cyc);
                check_output("ready_port", req1_ready, mon_e.port);
                check_output("ready_rdata", req1_ready ? req1_rdata : req0_rdata, mon_e.rdata);
                check_output("done_rw", mem_rw, mon_e.rw);
                check_output("done_addr", mem_addr, mon_e.addr);
                check_output("done_wdata", mem_wdata, mon_e.wdata);
                check_output("done_busy", busy, 1);
            end
        end
    end

    always @(negedge clk) begin
        if (b_req0_ready || b_req1_ready) begin
            if (q_b.size() == 0) begin
                checks++; errors++;
                $display("[TB] FAIL w1_unexpected_ready: ready at cycle %0d, expected none", cyc);
            end else begin
                mon_b = q_b.pop_front();
                check_output("w1_ready_cycle", cyc, mon_b.ready_cyc);
                check_output("w1_ready_port", b_req1_ready, mon_b.port);
                check_output("w1_rdata", b_req0_rdata, mon_b.rdata);
            end
        end
    end

    initial begin
        int t;
        access_t eb;
        req0_strobe = 0; req0_rw = 0; req0_addr = '0; req0_wdata = '0;
        req1_strobe = 0; req1_rw = 0; req1_addr = '0; req1_wdata = '0;
        b_req0_strobe = 0; b_req0_addr = '0;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1 check_idle_outputs("reset");
        step(2);
        reset = 1'b1;

        // Port 0 read.
        t = cyc;
        drive_port(0, 1'b0, 16'h0010, 8'h00);
        expect_access(0, 1'b0, 16'h0010, 8'h00, t + 2, t + 7, 1);
        apply_stimulus();
        step(10);

        // Port 1 write leaves its rdata untouched.
        t = cyc;
        drive_port(1, 1'b1, 16'h0200, 8'h3C);
        expect_access(1, 1'b1, 16'h0200, 8'h3C, t + 2, t + 7, 1);
        apply_stimulus();
        step(10);

        // Simultaneous strobes, three rounds: grants alternate starting with port 0.
        for (int r = 0; r < 3; r++) begin
            t = cyc;
            drive_port(0, 1'b0, 16'h0100 + 16'(r), 8'h10 + 8'(r));
            drive_port(1, r[0], 16'h0300 + 16'(r), 8'h40 + 8'(r));
            expect_access(0, 1'b0, 16'h0100 + 16'(r), 8'h10 + 8'(r), t + 2, t + 7, 1);
            expect_access(1, r[0], 16'h0300 + 16'(r), 8'h40 + 8'(r), t + 9, t + 14, 1);
            apply_stimulus();
            step(15);
        end

        // Repeat strobe while pending is dropped; strobe during DONE is kept.
        t = cyc;
        drive_port(0, 1'b0, 16'h0040, 8'h00);
        expect_access(0, 1'b0, 16'h0040, 8'h00, t + 2, t + 7, 1);
        apply_stimulus();
        drive_port(0, 1'b0, 16'h0099, 8'h00);
        apply_stimulus();
        step(5);
        drive_port(0, 1'b0, 16'h0041, 8'h00);
        expect_access(0, 1'b0, 16'h0041, 8'h00, t + 9, t + 14, 1);
        apply_stimulus();
        drive_port(0, 1'b1, 16'h00FF, 8'hEE);
        apply_stimulus();
        step(10);

        // Reset during WAIT aborts the access with no ready pulse.
        t = cyc;
        drive_port(1, 1'b0, 16'h0077, 8'h00);
        expect_access(1, 1'b0, 16'h0077, 8'h00, t + 2, 0, 0);
        apply_stimulus();
        step(3);
        #2 reset = 1'b0;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        #1 check_idle_outputs("abort");
        step(2);
        reset = 1'b1;

        // First tie after reset goes to port 0.
        t = cyc;
        drive_port(0, 1'b0, 16'h0020, 8'h00);
        drive_port(1, 1'b0, 16'h0021, 8'h00);
        expect_access(0, 1'b0, 16'h0020, 8'h00, t + 2, t + 7, 1);
        expect_access(1, 1'b0, 16'h0021, 8'h00, t + 9, t + 14, 1);
        apply_stimulus();
        step(16);

        // Single wait state.
        t = cyc;
        b_req0_strobe = 1'b1;
        b_req0_addr   = 16'h0010;
        eb.port = 0; eb.rw = 1'b0; eb.addr = 16'h0010; eb.wdata = 8'h00;
        eb.rdata = 8'hA5; eb.issue_cyc = t + 2; eb.ready_cyc = t + 4;
        q_b.push_back(eb);
        apply_stimulus();
        step(8);

        check_output("issue_queue_empty", q_issue.size(), 0);
        check_output("ready_queue_empty", q_ready.size(), 0);
        check_output("w1_queue_empty", q_b.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
